// File: rtl/uart_display_tx.sv
// uart_display_tx: snapshots the 40-bit display word and sends it as one UART 8N1 packet.
// Optional checksum byte enabled by defining UART_DISPLAY_CHECKSUM_EN.
`default_nettype none

module uart_display_tx #(
    parameter int         CLK_HZ    = 27000000,
    parameter int         BAUD      = 115200,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] frame_in,
    input  logic        send_req,
    output logic        busy,
    output logic        frame_done,
    output logic        uart_tx
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_DISPLAY_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd6;
`else
    localparam logic [2:0] LAST_BYTE = 3'd5;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [39:0]      frame_reg;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [2:0]       byte_idx;
    logic             pending;
    logic [7:0]       cur_byte;
    logic [2:0]       next_bit;
    logic             bit_end;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign next_bit = bit_cnt + 3'd1;

`ifdef UART_DISPLAY_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = frame_reg[39:32] ^ frame_reg[31:24] ^ frame_reg[23:16]
                    ^ frame_reg[15:8]  ^ frame_reg[7:0];
`endif

    // Byte on the wire is selected from the latched snapshot, so frame_in may change freely.
    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_idx)
            3'd1:    cur_byte = frame_reg[39:32];
            3'd2:    cur_byte = frame_reg[31:24];
            3'd3:    cur_byte = frame_reg[23:16];
            3'd4:    cur_byte = frame_reg[15:8];
            3'd5:    cur_byte = frame_reg[7:0];
`ifdef UART_DISPLAY_CHECKSUM_EN
            3'd6:    cur_byte = checksum;
`endif
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frame_reg  <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            pending    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            uart_tx    <= 1'b1;
        end else begin
            frame_done <= 1'b0;
            if (send_req && (state == START || state == DATA || state == STOP)) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (send_req) begin
                        frame_reg <= frame_in;
                        state     <= START;
                        busy      <= 1'b1;
                        uart_tx   <= 1'b0;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        byte_idx  <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        uart_tx  <= cur_byte[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= next_bit;
                            uart_tx <= cur_byte[next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_idx == LAST_BYTE) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            // A request seen on this very edge still counts as pending.
                            busy       <= pending | send_req;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            uart_tx  <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (pending || send_req) begin
                        pending   <= 1'b0;
                        frame_reg <= frame_in;
                        state     <= START;
                        busy      <= 1'b1;
                        uart_tx   <= 1'b0;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        byte_idx  <= '0;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_display_tx.sv
// tb_uart_display_tx: scoreboard bench for uart_display_tx (CLKS_PER_BIT = 4).
`default_nettype none

`ifdef UART_DISPLAY_CHECKSUM_EN
`define PUSH_CHK(v) exp_q.push_back(v)
`else
`define PUSH_CHK(v)
`endif

module tb_uart_display_tx;

    localparam int CPB = 4;
`ifdef UART_DISPLAY_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    localparam int TOT = 10 * CPB * NB;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] frame_in;
    logic        send_req;
    logic        busy;
    logic        frame_done;
    logic        uart_tx;

    uart_display_tx #(
        .CLK_HZ   (400),
        .BAUD     (100),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_in  (frame_in),
        .send_req  (send_req),
        .busy      (busy),
        .frame_done(frame_done),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];
    int         done_q[$];

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endfunction

    function automatic void fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s", nm);
    endfunction

    // Line decoder: every clock of every bit must hold the level seen on its first clock.
    initial begin
        int         mon_cnt;
        bit         mon_on;
        bit         mon_bad;
        logic [9:0] mon_bits;
        mon_on = 0;
        mon_cnt = 0;
        mon_bad = 0;
        mon_bits = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_on = 0;
            end else if (!mon_on) begin
                if (uart_tx === 1'b0) begin
                    mon_on = 1;
                    mon_cnt = 0;
                    mon_bad = 0;
                    mon_bits = '0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt % CPB == 0) mon_bits[mon_cnt / CPB] = uart_tx;
                else if (uart_tx !== mon_bits[mon_cnt / CPB]) mon_bad = 1;
                if (mon_cnt == 10 * CPB - 1) begin
                    mon_on = 0;
                    check("byte framing {glitch,start,stop}", {mon_bad, mon_bits[0], mon_bits[9]}, 3'b001);
                    if (exp_q.size() == 0) fail("unexpected byte on line");
                    else check("byte value", mon_bits[8:1], exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && frame_done === 1'b1) begin
                if (done_q.size() == 0) fail("unexpected frame_done");
                else check("frame_done cycle", cyc, done_q.pop_front());
            end
        end
    end

    // Called on a negedge with the DUT idle; acceptance happens on the next posedge.
    task automatic send(input logic [39:0] f);
        frame_in = f;
        send_req = 1'b1;
        exp_q.push_back(8'hA5);
        for (int i = 4; i >= 0; i--) exp_q.push_back(f[i*8 +: 8]);
        done_q.push_back(cyc + 1 + TOT);
        @(negedge clk);
        send_req = 1'b0;
        check("busy/uart_tx after accept", {busy, uart_tx}, 2'b10);
    endtask

    task automatic wait_idle(output int t);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail("busy timeout");
        t = cyc;
    endtask

    typedef struct {
        logic [39:0] frame;
        logic [7:0]  chk;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int t;
        int a;
        bit bad;
        tbl[0] = '{40'h5A_76543210, 8'h5A};
        tbl[1] = '{40'h00_FFFFFFFF, 8'h00};
        tbl[2] = '{40'h81_12345678, 8'h89};
        tbl[3] = '{40'hC3_0F1E2D3C, 8'hC3};

        rst = 1'b1;
        send_req = 1'b0;
        frame_in = '0;
        repeat (3) @(negedge clk);
        check("reset {uart_tx,busy,frame_done}", {uart_tx, busy, frame_done}, 3'b100);
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad = 1;
        end
        check("idle outputs disturbed", bad, 0);

        // Single packets from the table
        for (int i = 0; i < 4; i++) begin
            a = cyc + 1;
            send(tbl[i].frame);
            `PUSH_CHK(tbl[i].chk);
            wait_idle(t);
            check("busy drop cycle", t, a + TOT);
            repeat (3) @(negedge clk);
            check("bytes outstanding", exp_q.size(), 0);
            check("frame_done outstanding", done_q.size(), 0);
        end

        // Request while busy: second packet follows after one DONE cycle
        a = cyc + 1;
        send(40'h5A_76543210);
        `PUSH_CHK(8'h5A);
        bad = 0;
        while (cyc < a + 2 * TOT + 1) begin
            if (cyc == a + 20) begin
                frame_in = 40'hFF_00000000;
                send_req = 1'b1;
                exp_q.push_back(8'hA5);
                exp_q.push_back(8'hFF);
                repeat (4) exp_q.push_back(8'h00);
                `PUSH_CHK(8'hFF);
                done_q.push_back(a + 2 * TOT + 1);
            end else begin
                send_req = 1'b0;
            end
            if (cyc == a + TOT + 1) check("second start bit", uart_tx, 1'b0);
            if (busy !== 1'b1) bad = 1;
            @(negedge clk);
        end
        check("busy dropped between packets", bad, 0);
        wait_idle(t);
        check("busy drop after second packet", t, a + 2 * TOT + 1);
        repeat (3) @(negedge clk);
        check("bytes outstanding after pending", exp_q.size(), 0);

        // Reset during the third byte's data bits
        a = cyc + 1;
        send(40'h81_12345678);
        `PUSH_CHK(8'h89);
        while (cyc < a + 94) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async reset {uart_tx,busy}", {uart_tx, busy}, 2'b10);
        exp_q.delete();
        done_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad = 1;
        end
        check("line quiet after reset", bad, 0);
        a = cyc + 1;
        send(40'hC3_0F1E2D3C);
        `PUSH_CHK(8'hC3);
        wait_idle(t);
        check("clean packet after reset", t, a + TOT);
        repeat (3) @(negedge clk);
        check("bytes outstanding after reset", exp_q.size(), 0);

        // frame_in scrambled every clock during a packet
        send(40'h5A_76543210);
        `PUSH_CHK(8'h5A);
        t = 0;
        while (busy === 1'b1 && t < 2000) begin
            frame_in = {8'($urandom), 32'($urandom)};
            @(negedge clk);
            t++;
        end
        if (t >= 2000) fail("busy timeout with scrambled frame_in");
        repeat (3) @(negedge clk);
        check("bytes outstanding after scramble", exp_q.size(), 0);
        check("frame_done outstanding at end", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`undef PUSH_CHK

`default_nettype wire
